// File: rtl/seq_pkg.sv
// Shared types and helpers for the program sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    // Sequencer phases: waiting for a start, fetching, finished.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int D_DEFAULT = 12;
    localparam int C_DEFAULT = 16;

    // The helper is computed at a fixed width. Callers zero-extend their PC
    // into it and truncate the result back to D bits. Because only the low
    // D bits are kept, relative branches wrap modulo 2^D and the sequential
    // increment wraps from all ones to zero.
    localparam int PC_FN_W = 32;

    // Absolute jumps win over relative jumps, which win over the plain
    // sequential increment.
    function automatic logic [PC_FN_W-1:0] next_pc(
        input logic [PC_FN_W-1:0] pc,
        input logic [PC_FN_W-1:0] target,
        input logic               absjump,
        input logic               reljump
    );
        if (absjump) begin
            return target;
        end else if (reljump) begin
            return pc + target;
        end else begin
            return pc + PC_FN_W'(1);
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that sticks at all ones.
// Latency: count updates on the clk edge after en or clr is sampled.
// Backpressure: none; en simply gates the increment.
//
// Ports: clk, reset (sync, active-high), clr (sync clear), en (count enable),
//        count[C-1:0] (registered value).
module sat_counter #(
    parameter int C = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [C-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + C'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Instruction-fetch sequencer: start/done handshake, stall, branches, halt, watchdog.
// Latency: run rises one cycle after req is seen in IDLE; done rises one cycle after halt.
// Backpressure: stall holds prog_ctr for the cycle; req held high keeps DONE latched.
//
// Ports: clk, reset (sync, active-high), req (start, level), stall (hold PC),
//        absjump/reljump/target (branch from decoder), prog_ctr (fetch address
//        to instruction ROM), run, done, timeout (watchdog finish), cycle_cnt
//        (RUN cycles elapsed, saturating).
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int           D          = D_DEFAULT,
    parameter logic [D-1:0] RESET_VEC  = '0,
    parameter logic [D-1:0] HALT_ADDR  = '1,
    parameter int           C          = C_DEFAULT,
    parameter logic [C-1:0] MAX_CYCLES = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         stall,
    input  logic         absjump,
    input  logic         reljump,
    input  logic [D-1:0] target,
    output logic [D-1:0] prog_ctr,
    output logic         run,
    output logic         done,
    output logic         timeout,
    output logic [C-1:0] cycle_cnt
);

    state_t       state;
    state_t       state_nxt;
    logic [D-1:0] pc_nxt;
    logic         timeout_nxt;
    logic         cnt_clr;
    logic         cnt_en;
    logic         wd_hit;
    logic         halt_hit;

    // A zero limit turns the watchdog off entirely.
    assign wd_hit   = (MAX_CYCLES != '0) && (cycle_cnt == MAX_CYCLES);
    // A stalled fetch at the halt address has not really been issued yet,
    // so the halt waits until the stall drops.
    assign halt_hit = (prog_ctr == HALT_ADDR) && !stall;

    assign run  = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = prog_ctr;
        timeout_nxt = timeout;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt   = RUN;
                    pc_nxt      = RESET_VEC;
                    timeout_nxt = 1'b0;
                    cnt_clr     = 1'b1;
                end
            end
            RUN: begin
                // Every RUN cycle counts, including the one that finishes.
                cnt_en = 1'b1;
                if (wd_hit) begin
                    state_nxt   = DONE;
                    timeout_nxt = 1'b1;
                end else if (halt_hit) begin
                    state_nxt   = DONE;
                    timeout_nxt = 1'b0;
                end else if (!stall) begin
                    pc_nxt = D'(next_pc(PC_FN_W'(prog_ctr), PC_FN_W'(target),
                                        absjump, reljump));
                end
            end
            DONE: begin
                // No auto-restart: the host must drop req before a new start.
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prog_ctr <= RESET_VEC;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            prog_ctr <= pc_nxt;
            timeout  <= timeout_nxt;
        end
    end

    sat_counter #(
        .C(C)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cycle_cnt)
    );

endmodule

// File: tb/tb_prog_sequencer.sv
// Three sequencer instances with different RESET_VEC / HALT_ADDR / watchdog
// settings share one stimulus stream; a behavioural model predicts each
// instance's outputs after every edge and a monitor compares them.
module tb_prog_sequencer;

    localparam int N = 3;
    localparam int D = 4;
    localparam int C = 5;
    localparam int RV_P   [N] = '{0, 3, 7};
    localparam int HALT_P [N] = '{15, 12, 7};
    localparam int MAX_P  [N] = '{0, 10, 0};
    localparam int CNT_SAT = (1 << C) - 1;
    localparam int PC_MOD  = 1 << D;

    typedef struct packed {
        logic [N-1:0][D-1:0] pc;
        logic [N-1:0]        run;
        logic [N-1:0]        done;
        logic [N-1:0]        to;
        logic [N-1:0][C-1:0] cnt;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         req;
    logic         stall;
    logic         absjump;
    logic         reljump;
    logic [D-1:0] target;

    logic [D-1:0] pc_d   [N];
    logic         run_d  [N];
    logic         done_d [N];
    logic         to_d   [N];
    logic [C-1:0] cnt_d  [N];

    exp_t exp_q[$];
    int   checks;
    int   passed;

    // Reference model state: plain integers and flags.
    int m_pc   [N];
    int m_cnt  [N];
    int m_to   [N];
    bit m_busy [N];
    bit m_fin  [N];

    prog_sequencer #(.D(D), .RESET_VEC(4'd0), .HALT_ADDR(4'd15), .C(C), .MAX_CYCLES(5'd0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .stall(stall), .absjump(absjump),
        .reljump(reljump), .target(target), .prog_ctr(pc_d[0]), .run(run_d[0]),
        .done(done_d[0]), .timeout(to_d[0]), .cycle_cnt(cnt_d[0]));

    prog_sequencer #(.D(D), .RESET_VEC(4'd3), .HALT_ADDR(4'd12), .C(C), .MAX_CYCLES(5'd10)) dut1 (
        .clk(clk), .reset(reset), .req(req), .stall(stall), .absjump(absjump),
        .reljump(reljump), .target(target), .prog_ctr(pc_d[1]), .run(run_d[1]),
        .done(done_d[1]), .timeout(to_d[1]), .cycle_cnt(cnt_d[1]));

    prog_sequencer #(.D(D), .RESET_VEC(4'd7), .HALT_ADDR(4'd7), .C(C), .MAX_CYCLES(5'd0)) dut2 (
        .clk(clk), .reset(reset), .req(req), .stall(stall), .absjump(absjump),
        .reljump(reljump), .target(target), .prog_ctr(pc_d[2]), .run(run_d[2]),
        .done(done_d[2]), .timeout(to_d[2]), .cycle_cnt(cnt_d[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        exp_t e;
        bit   wd;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_busy[i] = 1'b0;
                m_fin[i]  = 1'b0;
                m_pc[i]   = RV_P[i];
                m_cnt[i]  = 0;
                m_to[i]   = 0;
            end else if (m_busy[i]) begin
                wd = (MAX_P[i] != 0) && (m_cnt[i] == MAX_P[i]);
                if (wd) begin
                    m_busy[i] = 1'b0;
                    m_fin[i]  = 1'b1;
                    m_to[i]   = 1;
                end else if (m_pc[i] == HALT_P[i] && !stall) begin
                    m_busy[i] = 1'b0;
                    m_fin[i]  = 1'b1;
                    m_to[i]   = 0;
                end else if (!stall) begin
                    if (absjump)      m_pc[i] = int'(target);
                    else if (reljump) m_pc[i] = (m_pc[i] + int'(target)) % PC_MOD;
                    else              m_pc[i] = (m_pc[i] + 1) % PC_MOD;
                end
                m_cnt[i] = (m_cnt[i] < CNT_SAT) ? m_cnt[i] + 1 : CNT_SAT;
            end else if (m_fin[i]) begin
                if (!req) m_fin[i] = 1'b0;
            end else if (req) begin
                m_busy[i] = 1'b1;
                m_pc[i]   = RV_P[i];
                m_cnt[i]  = 0;
                m_to[i]   = 0;
            end
            e.pc[i]   = D'(m_pc[i]);
            e.run[i]  = m_busy[i];
            e.done[i] = m_fin[i];
            e.to[i]   = m_to[i][0];
            e.cnt[i]  = C'(m_cnt[i]);
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic q, input logic s,
                       input logic a, input logic rl, input logic [D-1:0] t);
        @(negedge clk);
        reset   = r;
        req     = q;
        stall   = s;
        absjump = a;
        reljump = rl;
        target  = t;
        model_step();
    endtask

    task automatic plain(input logic q, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, q, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("dut%0d prog_ctr", i),  int'(pc_d[i]),   int'(e.pc[i]));
                    chk($sformatf("dut%0d run", i),       int'(run_d[i]),  int'(e.run[i]));
                    chk($sformatf("dut%0d done", i),      int'(done_d[i]), int'(e.done[i]));
                    chk($sformatf("dut%0d timeout", i),   int'(to_d[i]),   int'(e.to[i]));
                    chk($sformatf("dut%0d cycle_cnt", i), int'(cnt_d[i]),  int'(e.cnt[i]));
                end
            end
        end
    end

    initial begin
        checks  = 0;
        passed  = 0;
        reset   = 1'b1;
        req     = 1'b0;
        stall   = 1'b0;
        absjump = 1'b0;
        reljump = 1'b0;
        target  = '0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        plain(1'b0, 3);

        // Straight-line run with branch priority, relative back-jump and stalls.
        plain(1'b1, 1);
        plain(1'b0, 5);                                  // dut0 at 5
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9);         // abs wins -> 9
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD);         // 9 + (-3) -> 6
        plain(1'b0, 1);                                  // -> 7
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        plain(1'b0, 8);                                  // dut0 at 15
        for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        plain(1'b0, 3);                                  // halt -> DONE
        plain(1'b1, 3);                                  // req held: stays DONE
        plain(1'b0, 2);

        // Relative wrap: jump to 14 then add 3.
        plain(1'b1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd14);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        plain(1'b0, 20);
        plain(1'b0, 2);

        // Watchdog: tight absolute-jump loop.
        plain(1'b1, 1);
        for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        plain(1'b0, 2);
        plain(1'b1, 1);                                  // restart clears timeout
        plain(1'b0, 3);

        // Reset in the middle of a run.
        plain(1'b0, 20);
        plain(1'b0, 2);
        plain(1'b1, 1);
        plain(1'b0, 6);                                  // dut0 at 6
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        plain(1'b0, 3);
        plain(1'b1, 1);
        plain(1'b0, 2);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), D'($urandom_range(0, 15)));
        end
        plain(1'b0, 3);

        @(posedge clk);
        #2;
        chk("expect_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Parametrised successor to the core's program counter and done logic.
- Owns instruction fetch sequencing: start/finish handshake with the host (req/done), a stall hold, absolute and relative branch resolution, halt-address detection, and a watchdog cycle counter that forces termination.
- Sits between the control decoder (branch requests, target) and instr_ROM (prog_ctr).

Parameters:
- D, 12, program counter width in bits.
- RESET_VEC, 0, PC value loaded on reset and on every start.
- HALT_ADDR, all ones (2^D-1), fetch address that ends the program.
- C, 16, cycle counter width.
- MAX_CYCLES, 2^C-1, watchdog limit; a value of 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request, level-sensitive.
- stall  in  1  hold the PC for this cycle.
- absjump  in  1  load target as the next PC.
- reljump  in  1  add target to the PC.
- target  in  D  absolute address or two's-complement offset.
- prog_ctr  out  D  current fetch address.
- run  out  1  prog_ctr is valid and executing.
- done  out  1  program finished, level.
- timeout  out  1  finish was caused by the watchdog.
- cycle_cnt  out  C  RUN cycles elapsed, saturating.

Behaviour:
- All state is registered on the clk rising edge. reset has priority over every other input.
- Reset values: state=IDLE, prog_ctr=RESET_VEC, run=0, done=0, timeout=0, cycle_cnt=0.
- IDLE:
  - run=0, done=0.
  - req=1 → RUN on the next edge; prog_ctr<=RESET_VEC, cycle_cnt<=0, timeout<=0.
- RUN (run=1), evaluated in this priority order:
  - Watchdog: MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES → DONE, timeout<=1, prog_ctr holds.
  - Halt: prog_ctr==HALT_ADDR and stall=0 → DONE, timeout<=0, prog_ctr holds. Branch inputs are ignored in this cycle.
  - Stall: stall=1 → prog_ctr holds; cycle_cnt still increments.
  - Branch: absjump=1 → prog_ctr<=target. absjump wins if reljump is also 1.
  - Relative: reljump=1 → prog_ctr<=prog_ctr+target, D-bit two's-complement, wraps modulo 2^D.
  - Otherwise prog_ctr<=prog_ctr+1, wrapping from 2^D-1 to 0 (only reachable if HALT_ADDR is not all ones).
  - cycle_cnt<=cycle_cnt+1 every RUN cycle, saturating at 2^C-1.
  - req is ignored in RUN; dropping req does not abort.
- DONE:
  - done=1, run=0; prog_ctr, cycle_cnt and timeout are frozen.
  - req=0 → IDLE next edge. done falls in that same cycle, so the host sees done for at least one cycle.
  - req held at 1 → stay in DONE; there is no auto-restart.
- Latency:
  - req sampled high in IDLE → run=1 one cycle later, fetching RESET_VEC.
  - Halt address presented → done=1 one cycle later.
- Reset mid-RUN or mid-DONE → IDLE with reset values on the next edge; no done pulse is emitted.
- Watchdog and halt both true in the same cycle → watchdog wins; timeout=1.
- RESET_VEC==HALT_ADDR → the first RUN cycle halts, so the program executes 1 cycle.

Decomposition:
- Shared package seq_pkg:
  - State enum typedef {IDLE, RUN, DONE}, 2 bits.
  - Default constants for D and C.
  - Helper function next_pc(pc, target, absjump, reljump).
- One natural sub-module: sat_counter (parameter C; ports clk, reset, clr, en, count), used for cycle_cnt.
- Everything else lives in prog_sequencer.

Test Plan:
- Straight-line run: D=4, RESET_VEC=0, HALT_ADDR=15; reset, then req=1 for 1 cycle.
  - Required: prog_ctr walks 0..15 with run=1.
  - done=1 appears the cycle after prog_ctr=15.
  - cycle_cnt=16, timeout=0.
- Branch priority: at prog_ctr=5 apply absjump=1, reljump=1, target=9 → next prog_ctr=9. Then reljump=1 with target=-3 (0xD for D=4) → prog_ctr=6.
- Relative wrap: D=4, prog_ctr=14, reljump=1, target=3 → prog_ctr=1. Use HALT_ADDR=12 so 15 is not a halt.
- Stall: stall=1 for 3 cycles at prog_ctr=7.
  - prog_ctr stays 7 for those 3 cycles.
  - cycle_cnt advances by 3.
  - stall at HALT_ADDR defers done until stall drops.
- Watchdog: MAX_CYCLES=10, absjump loop at target=2 → after cycle_cnt=10, done=1 and timeout=1. Then req=0 → IDLE; next req restarts with timeout=0 and cycle_cnt=0.
- Handshake and reset:
  - req held high through DONE → state stays DONE.
  - Assert reset while in RUN at prog_ctr=6 → next cycle prog_ctr=RESET_VEC, run=0, done=0, and the block stays in IDLE until req is asserted.
